// File: rtl/vid_in_to_axis.sv
// Parallel RGB capture (hsync/vsync, no DE) to AXI4-Stream video: tuser marks SOF, tlast marks EOL.
// Define VID_IN_MEASURE_EN to add meas_htotal/meas_vtotal timing measurement outputs.
module vid_in_to_axis #(
    parameter int   WIDTH      = 640,
    parameter int   HEIGHT     = 480,
    parameter int   H_START    = 144,
    parameter int   V_START    = 35,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] vid_data,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    input  logic        ovf_clr,
    output logic        ovf,
    output logic [15:0] frame_cnt
`ifdef VID_IN_MEASURE_EN
    ,
    output logic [15:0] meas_htotal,
    output logic [15:0] meas_vtotal
`endif
);
    localparam int HW = $clog2(H_START + WIDTH + 1);
    localparam int VW = $clog2(V_START + HEIGHT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_FIRST = HW'(H_START);
    localparam logic [HW-1:0] H_LAST  = HW'(H_START + WIDTH - 1);
    localparam logic [HW-1:0] H_END   = HW'(H_START + WIDTH);
    localparam logic [VW-1:0] V_FIRST = VW'(V_START);
    localparam logic [VW-1:0] V_LAST  = VW'(V_START + HEIGHT - 1);
    localparam logic [VW-1:0] V_END   = VW'(V_START + HEIGHT);

    typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DROP} state_t;

    logic [23:0]   data_q;
    logic          hs_q, hs_qq, vs_q, vs_qq;
    logic          hs_lead, vs_lead;
    logic [HW-1:0] hcnt, h_cur;
    logic [VW-1:0] vcnt, v_cur;
    logic          pix_active, pix_sof, pix_eol, pix_last;
    state_t        state_q, state_d;
    logic          wr_en, overflow;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [25:0]   mem [FIFO_DEPTH];
    logic [25:0]   head;
    logic          fifo_empty, fifo_full, rd_en;

    assign hs_lead = (hs_q == HS_POL) && (hs_qq != HS_POL);
    assign vs_lead = (vs_q == VS_POL) && (vs_qq != VS_POL);

    // Counts describe the pixel currently held in data_q; the registers keep the previous pixel's count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        h_cur = hcnt;
        v_cur = vcnt;
        if (hs_lead)
            h_cur = '0;
        else if (hcnt != H_END)
            h_cur = hcnt + 1'b1;
        if (vs_lead)
            v_cur = '0;
        else if (hs_lead && vcnt != V_END)
            v_cur = vcnt + 1'b1;
    end

    assign pix_active = (h_cur >= H_FIRST) && (h_cur < H_END) && (v_cur >= V_FIRST) && (v_cur < V_END);
    assign pix_sof    = (h_cur == H_FIRST) && (v_cur == V_FIRST);
    assign pix_eol    = (h_cur == H_LAST);
    assign pix_last   = pix_eol && (v_cur == V_LAST);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en      = !fifo_empty && m_axis_tready;

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        overflow = 1'b0;
        case (state_q)
            WAIT_FRAME: if (vs_lead) state_d = ACTIVE;
            ACTIVE: begin
                // A read in the same cycle frees the slot, so full alone is not an overflow.
                if (pix_active) begin
                    if (fifo_full && !rd_en) begin
                        overflow = 1'b1;
                        state_d  = DROP;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            DROP: if (vs_lead) state_d = ACTIVE;
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            data_q    <= '0;
            hs_q      <= ~HS_POL;
            hs_qq     <= ~HS_POL;
            vs_q      <= ~VS_POL;
            vs_qq     <= ~VS_POL;
            hcnt      <= '0;
            vcnt      <= '0;
            state_q   <= WAIT_FRAME;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            data_q  <= vid_data;
            hs_q    <= vid_hsync;
            hs_qq   <= hs_q;
            vs_q    <= vid_vsync;
            vs_qq   <= vs_q;
            hcnt    <= h_cur;
            vcnt    <= v_cur;
            state_q <= state_d;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (overflow)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            if (wr_en && pix_last)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {pix_sof, pix_eol, data_q};
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !fifo_empty;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_empty ? 26'd0 : head;

`ifdef VID_IN_MEASURE_EN
    logic [15:0] h_per, v_per;

    // Periods are counted from one leading edge to the next and latched when the next edge arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_per       <= '0;
            v_per       <= '0;
            meas_htotal <= '0;
            meas_vtotal <= '0;
        end else begin
            if (hs_lead) begin
                meas_htotal <= h_per;
                h_per       <= 16'd1;
            end else if (h_per != 16'hFFFF) begin
                h_per <= h_per + 1'b1;
            end
            if (vs_lead) begin
                meas_vtotal <= v_per;
                v_per       <= {15'd0, hs_lead};
            end else if (hs_lead && v_per != 16'hFFFF) begin
                v_per <= v_per + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_vid_in_to_axis.sv
// Randomised bench for vid_in_to_axis: raster generator, queue-based reference model, per-cycle compare.
// Small raster: 8x4 active, H_START 4, V_START 2, 16 clocks per line, 8 lines per frame.
module tb_vid_in_to_axis;
    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 4;
    localparam int H_START = 4;
    localparam int V_START = 2;
    localparam int DEPTH   = 16;
    localparam int HTOT    = 16;
    localparam int VTOT    = 8;

    logic        clk           = 1'b0;
    logic        rst           = 1'b1;
    logic [23:0] vid_data      = '0;
    logic        vid_hsync     = 1'b1;
    logic        vid_vsync     = 1'b1;
    logic        m_axis_tready = 1'b1;
    logic        ovf_clr       = 1'b0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, ovf;
    logic [15:0] frame_cnt;
`ifdef VID_IN_MEASURE_EN
    logic [15:0] meas_htotal, meas_vtotal;
`endif

    always #5 clk = ~clk;

    vid_in_to_axis #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_START(H_START), .V_START(V_START),
        .HS_POL(1'b0), .VS_POL(1'b0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .vid_data(vid_data), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .ovf_clr(ovf_clr), .ovf(ovf), .frame_cnt(frame_cnt)
`ifdef VID_IN_MEASURE_EN
        , .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal)
`endif
    );

    typedef enum {M_WAIT, M_ACTIVE, M_DROP} mstate_t;
    typedef struct {
        bit          valid;
        bit          act;
        bit          sof;
        bit          eol;
        bit          last;
        bit          vsl;
        logic [23:0] data;
    } pix_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          cmp_en = 1'b0;
    logic [25:0] q[$];
    logic [25:0] beats[$];
    mstate_t     ms       = M_WAIT;
    logic        m_ovf    = 1'b0;
    logic [15:0] m_frames = '0;
    pix_t        pv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] beat_at(input int i);
        if (i < beats.size())
            return beats[i];
        return 'x;
    endfunction

    // One pixel clock: drive inputs, then advance the model to the state after the coming edge.
    task automatic step(input logic hs, input logic vs, input logic [23:0] d, input pix_t px,
                        input logic rdy, input logic clr, input bit do_rst);
        bit rd, wr, oset;
        @(negedge clk);
        #1;
        rst           = do_rst;
        vid_hsync     = hs;
        vid_vsync     = vs;
        vid_data      = d;
        m_axis_tready = rdy;
        ovf_clr       = clr;
        cyc++;
        if (do_rst) begin
            #1;
            check("reset_tvalid_async", m_axis_tvalid, 1'b0);
            q.delete();
            beats.delete();
            ms       = M_WAIT;
            m_ovf    = 1'b0;
            m_frames = '0;
            pv.valid = 1'b0;
        end else begin
            rd   = (q.size() != 0) && rdy;
            wr   = 1'b0;
            oset = 1'b0;
            if (pv.valid) begin
                if (ms == M_ACTIVE && pv.act) begin
                    if (q.size() == DEPTH && !rd) begin
                        oset = 1'b1;
                        ms   = M_DROP;
                    end else begin
                        wr = 1'b1;
                    end
                end else if (ms != M_ACTIVE && pv.vsl) begin
                    ms = M_ACTIVE;
                end
            end
            if (rd)
                void'(q.pop_front());
            if (wr) begin
                q.push_back({pv.sof, pv.eol, pv.data});
                if (pv.last)
                    m_frames++;
            end
            if (oset)
                m_ovf = 1'b1;
            else if (clr)
                m_ovf = 1'b0;
            pv = px;
        end
    endtask

    task automatic idle(input int n, input logic rdy, input logic clr);
        for (int i = 0; i < n; i++) begin
            pix_t px;
            px       = '{default: 0};
            px.valid = 1'b1;
            px.data  = 24'($urandom);
            step(1'b1, 1'b1, px.data, px, rdy, clr && (i == 0), 1'b0);
        end
    endtask

    // rmode: 0 ready, 1 toggling, 2 stalled, 3 random, 4 stalled until the FIFO is exactly full.
    task automatic run_frame(input int lines, input int rmode, input bit ramp, input int rst_l, input int rst_c);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < HTOT; c++) begin
                pix_t px;
                logic rdy;
                px.valid = 1'b1;
                px.act   = (c >= H_START) && (c < H_START + WIDTH) && (l >= V_START) && (l < V_START + HEIGHT);
                px.sof   = (l == V_START) && (c == H_START);
                px.eol   = (c == H_START + WIDTH - 1);
                px.last  = px.eol && (l == V_START + HEIGHT - 1);
                px.vsl   = (l == 0) && (c == 0);
                px.data  = (ramp && px.act) ? {8'h00, 8'(l - V_START), 8'(c - H_START)} : 24'($urandom);
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = cyc[0];
                    2:       rdy = 1'b0;
                    3:       rdy = ($urandom_range(3) != 0);
                    default: rdy = (l > 4) || (l == 4 && c >= 5);
                endcase
                step(c >= 2, l >= 2, px.data, px, rdy, 1'b0, (l == rst_l) && (c == rst_c));
            end
        end
    endtask

    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready)
            beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("tvalid", m_axis_tvalid, q.size() != 0);
            if (q.size() != 0) begin
                check("tdata", m_axis_tdata, q[0][23:0]);
                check("tuser", m_axis_tuser, q[0][25]);
                check("tlast", m_axis_tlast, q[0][24]);
            end
            check("ovf", ovf, m_ovf);
            check("frame_cnt", frame_cnt, m_frames);
        end
    end

    initial begin
        logic [25:0] b;
        int          n_user, n_last;
        pv = '{default: 0};
        repeat (3) @(negedge clk);
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tuser", m_axis_tuser, 1'b0);
        check("reset_tlast", m_axis_tlast, 1'b0);
        check("reset_tdata", m_axis_tdata, 24'd0);
        check("reset_ovf", ovf, 1'b0);
        check("reset_frame_cnt", frame_cnt, 16'd0);
        cmp_en = 1'b1;
        idle(20, 1'b1, 1'b0);

        // Ramp over two back-to-back frames with tready held high.
        beats.delete();
        run_frame(VTOT, 0, 1'b1, -1, -1);
        run_frame(VTOT, 0, 1'b1, -1, -1);
        idle(40, 1'b1, 1'b0);
        check("t1_beats", beats.size(), 64);
        b = beat_at(0);
        check("t1_b0_tuser", b[25], 1'b1);
        check("t1_b0_data", b[23:0], 24'h000000);
        b = beat_at(7);
        check("t1_b7_tlast", b[24], 1'b1);
        b = beat_at(8);
        check("t1_b8_tuser", b[25], 1'b0);
        check("t1_b8_data", b[23:0], 24'h000100);
        b = beat_at(32);
        check("t1_b32_tuser", b[25], 1'b1);
        n_user = 0;
        n_last = 0;
        foreach (beats[i]) begin
            n_user += int'(beats[i][25]);
            n_last += int'(beats[i][24]);
        end
        check("t1_tuser_count", n_user, 2);
        check("t1_tlast_count", n_last, 8);
        check("t1_frame_cnt", frame_cnt, 16'd2);
`ifdef VID_IN_MEASURE_EN
        check("meas_htotal", meas_htotal, 16'd16);
        check("meas_vtotal", meas_vtotal, 16'd8);
`endif

        // tready toggling every cycle.
        beats.delete();
        run_frame(VTOT, 1, 1'b1, -1, -1);
        run_frame(VTOT, 1, 1'b1, -1, -1);
        idle(40, 1'b1, 1'b0);
        check("t2_beats", beats.size(), 64);
        b = beat_at(9);
        check("t2_b9_data", b[23:0], 24'h000101);
        check("t2_ovf", ovf, 1'b0);
        check("t2_frame_cnt", frame_cnt, 16'd4);

        // FIFO exactly full when a read and a write coincide: no overflow.
        beats.delete();
        run_frame(VTOT, 4, 1'b1, -1, -1);
        idle(40, 1'b1, 1'b0);
        check("tf_ovf", ovf, 1'b0);
        check("tf_beats", beats.size(), 32);
        check("tf_frame_cnt", frame_cnt, 16'd5);

        // Stalled for a whole frame: overflow on pixel 17, recovery on the next frame.
        beats.delete();
        run_frame(VTOT, 2, 1'b1, -1, -1);
        check("t3_ovf_set", ovf, 1'b1);
        check("t3_tvalid_held", m_axis_tvalid, 1'b1);
        idle(40, 1'b1, 1'b0);
        run_frame(VTOT, 0, 1'b1, -1, -1);
        idle(40, 1'b1, 1'b0);
        check("t3_beats", beats.size(), 48);
        b = beat_at(15);
        check("t3_b15_data", b[23:0], 24'h000107);
        check("t3_b15_tlast", b[24], 1'b1);
        b = beat_at(16);
        check("t3_b16_tuser", b[25], 1'b1);
        check("t3_frame_cnt", frame_cnt, 16'd6);
        idle(2, 1'b1, 1'b1);
        check("t3_ovf_clr", ovf, 1'b0);

        // Short frame: vsync after two active lines.
        beats.delete();
        run_frame(4, 0, 1'b1, -1, -1);
        check("t4_short_frame_cnt", frame_cnt, 16'd6);
        run_frame(VTOT, 0, 1'b1, -1, -1);
        idle(40, 1'b1, 1'b0);
        check("t4_beats", beats.size(), 48);
        b = beat_at(16);
        check("t4_b16_tuser", b[25], 1'b1);
        check("t4_b16_data", b[23:0], 24'h000000);
        check("t4_frame_cnt", frame_cnt, 16'd7);

        // Random data and random backpressure.
        beats.delete();
        run_frame(VTOT, 3, 1'b0, -1, -1);
        run_frame(VTOT, 3, 1'b0, -1, -1);
        idle(40, 1'b1, 1'b0);
        check("tr_beats", beats.size(), 64);
        check("tr_frame_cnt", frame_cnt, 16'd9);

        // Reset pulsed mid-line.
        run_frame(VTOT, 0, 1'b1, 3, 6);
        idle(20, 1'b1, 1'b0);
        check("t5_no_beats", beats.size(), 0);
        check("t5_frame_cnt_rst", frame_cnt, 16'd0);
        run_frame(VTOT, 0, 1'b1, -1, -1);
        idle(40, 1'b1, 1'b0);
        check("t5_beats", beats.size(), 32);
        b = beat_at(0);
        check("t5_b0_tuser", b[25], 1'b1);
        check("t5_b0_data", b[23:0], 24'h000000);
        check("t5_frame_cnt", frame_cnt, 16'd1);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
